// File: rtl/tt_haz_if.sv
// Decode-slot, branch-resolution and resolver-feedback bundle for tt_haz_detect.
// The master side drives instructions and resolver feedback; the slave is the detector.
interface tt_haz_if #(
  parameter int REG_W = 3
);
  logic             in_valid;
  logic [REG_W-1:0] in_rs1;
  logic [REG_W-1:0] in_rs2;
  logic             in_uses_rs2;
  logic [REG_W-1:0] in_rd;
  logic             in_is_load;
  logic             in_is_store;
  logic             in_is_branch;
  logic             br_res_valid;
  logic             br_taken;
  logic             pc_freeze;
  logic             do_flush;
  logic [7:0]       haz_vec;
  logic [2:0]       stage_valid;
  logic [7:0]       stall_cnt;

  modport master (
    output in_valid, in_rs1, in_rs2, in_uses_rs2, in_rd, in_is_load, in_is_store,
           in_is_branch, br_res_valid, br_taken, pc_freeze, do_flush,
    input  haz_vec, stage_valid, stall_cnt
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_uses_rs2, in_rd, in_is_load, in_is_store,
           in_is_branch, br_res_valid, br_taken, pc_freeze, do_flush,
    output haz_vec, stage_valid, stall_cnt
  );
endinterface

// File: rtl/tt_haz_detect.sv
// Hazard detector feeding the tt_fsm_haz resolver: tracks EX/MEM/WB destinations,
// flags data/store/control hazards one cycle later and keeps a 2-bit branch predictor.
module tt_haz_detect #(
  parameter int         REG_W     = 3,
  parameter logic [1:0] PRED_INIT = 2'b01
) (
  input  logic      clk,
  input  logic      rst_n,
  tt_haz_if.slave   bus
);
  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
    logic             we;
  } ent_t;

  ent_t [2:0] stg, stg_nxt;
  ent_t       dec;
  logic [1:0] mtch;
  logic       data, fwrd, str, ctrl;
  logic [3:0] flg_q;   // {data, str, ctrl, fwrd}
  logic       crct;
  logic [1:0] ctr;
  logic [7:0] stall_q;

  always_comb begin
    dec.valid   = bus.in_valid;
    dec.rd      = bus.in_rd;
    dec.is_load = bus.in_is_load;
    dec.we      = ~bus.in_is_store & ~bus.in_is_branch & (bus.in_rd != '0);
    mtch = '0;
    // WB is excluded: the register file writes through to decode.
    for (int s = EX; s <= MEM; s++)
      mtch[s] = stg[s].valid & stg[s].we &
                ((stg[s].rd == bus.in_rs1) | (bus.in_uses_rs2 & (stg[s].rd == bus.in_rs2)));
    data = bus.in_valid & (|mtch);
    fwrd = data & ~(mtch[EX] & stg[EX].is_load);
    str  = bus.in_valid & bus.in_is_store & (|mtch);
    ctrl = bus.in_valid & bus.in_is_branch;
  end

  always_comb begin
    stg_nxt[WB]  = stg[MEM];
    stg_nxt[MEM] = stg[EX];
    stg_nxt[EX]  = bus.in_valid ? dec : '0;
    if (bus.do_flush) begin
      stg_nxt[EX]  = '0;
      stg_nxt[MEM] = '0;
    end else if (bus.pc_freeze) begin
      stg_nxt[EX]  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg     <= '0;
      flg_q   <= '0;
      crct    <= 1'b1;
      ctr     <= PRED_INIT;
      stall_q <= '0;
    end else begin
      stg   <= stg_nxt;
      flg_q <= bus.do_flush ? 4'b0000 : {data, str, ctrl, fwrd};
      if (bus.br_res_valid) begin
        crct <= (bus.br_taken == ctr[1]);
        if (bus.br_taken && ctr != 2'b11)       ctr <= ctr + 2'b01;
        else if (!bus.br_taken && ctr != 2'b00) ctr <= ctr - 2'b01;
      end
      if (bus.pc_freeze && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end
  end

  assign bus.haz_vec     = {flg_q[3], flg_q[2], 1'b0, flg_q[1], flg_q[0], crct, 2'b00};
  assign bus.stage_valid = {stg[WB].valid, stg[MEM].valid, stg[EX].valid};
  assign bus.stall_cnt   = stall_q;
endmodule
